mac_div_seq: RTL
================

Name: mac_div_seq

Overview:
- Sequential unsigned restoring divider; the inverse datapath companion to the team's MAC unit.
- Takes a DW-bit dividend (an accumulator-width value) and a VW-bit divisor (an operand-width value).
- Produces quotient and remainder, one quotient bit per cycle.
- valid/ready handshake on both sides; sits after the MAC accumulator for normalisation/averaging.

Parameters:
- DW, 16, dividend and quotient width.
- VW, 8, divisor and remainder width; VW <= DW.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- dividend  in  DW  numerator.
- divisor  in  VW  denominator.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- quotient  out  DW  floor(dividend/divisor).
- remainder  out  VW  dividend mod divisor.
- div_by_zero  out  1  result flag: divisor was 0.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - Accept on in_valid&&in_ready at a rising edge; latch dividend into the quotient/shift register and the divisor into the divisor register.
  - Clear the partial remainder (VW+1 bits) and load counter=DW.
  - divisor==0 -> DONE directly, quotient=all ones, remainder=dividend[VW-1:0], div_by_zero=1.
  - Otherwise -> BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle: shift {partial remainder, quotient register} left by 1.
  - If shifted partial >= {1'b0,divisor}: subtract and set quotient LSB=1; else quotient LSB=0.
  - Decrement counter; when counter reaches 1 in this cycle -> DONE.
  - Exactly DW cycles in BUSY.
- DONE:
  - out_valid=1; quotient, remainder and div_by_zero held stable while out_ready=0.
  - out_valid&&out_ready -> IDLE next edge; out_valid drops.
  - No new input is accepted in DONE: in_ready=0.
- Latency:
  - Acceptance edge at cycle 0; out_valid is high after edge DW+1 (17 for the default).
  - Divide-by-zero: out_valid high after edge 1.
  - Minimum back-to-back issue interval is DW+2 cycles.
- Width rules:
  - Unsigned only.
  - Partial remainder is VW+1 bits so the compare cannot overflow.
  - Final remainder < divisor, so it always fits VW bits.
- Boundary conditions:
  - dividend=0 -> quotient 0, remainder 0 after full latency.
  - divisor=1 -> quotient=dividend, remainder 0.
  - dividend=all ones with divisor=all ones is exact.
- Simultaneous events and reset:
  - in_valid asserted during BUSY/DONE is ignored (not acknowledged); the operand must be held by the source.
  - reset asserted in any state, including mid-BUSY or DONE with out_ready=0, returns to IDLE at that edge; the in-flight result is discarded and out_valid=0 the next cycle.
- Result registers are undefined-free: they only update on the state transitions above.

Optional Feature:
- Macro: MAC_DIV_SEQ_EARLY_EXIT_EN.
- Defined: in IDLE, if divisor!=0 and dividend < divisor (zero-extended compare), go straight to DONE.
  - quotient=0, remainder=dividend[VW-1:0], div_by_zero=0.
  - Latency is 1 edge, same as divide-by-zero.
- Undefined: no such comparator; these cases take the full DW-cycle BUSY path and produce identical results at DW+1 latency.

Decomposition:
- Shared package mac_pkg:
  - state enum typedef (IDLE/BUSY/DONE);
  - default width constants DW/VW;
  - counter width constant $clog2(DW+1).
- One natural sub-module, mac_div_step: combinational single-iteration restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - The top holds the FSM, counter, handshake and registers.

Test Plan:
- dividend=1000, divisor=7, out_ready=1 -> quotient=142, remainder=6, div_by_zero=0; out_valid rises exactly 17 edges after acceptance; in_ready low throughout.
- dividend=0xFFFF, divisor=0xFF -> quotient=257, remainder=0; then dividend=0xFFFF, divisor=1 -> quotient=0xFFFF, remainder=0.
- Divide by zero:
  - Stimulus: dividend=0x1234, divisor=0.
  - Response: 1 edge later out_valid=1, quotient=0xFFFF, remainder=0x34, div_by_zero=1.
- Backpressure: dividend=100, divisor=9 with out_ready=0 for 5 cycles after out_valid -> quotient=11, remainder=1 held stable; in_valid ignored; single handshake on out_ready=1, then in_ready=1 next cycle.
- Reset mid-operation: assert reset 8 cycles into BUSY -> next cycle state IDLE, out_valid=0, in_ready=1, outputs 0; a following 50/5 yields quotient=10, remainder=0.
- Early exit: dividend=5, divisor=9:
  - with MAC_DIV_SEQ_EARLY_EXIT_EN -> quotient=0, remainder=5 after 1 edge;
  - without it -> same values after 17 edges.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC datapath blocks.
package mac_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_VW = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEF_DW);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/mac_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// conditionally subtract the divisor from the partial remainder.
module mac_div_step #(
  parameter int VW = 8
) (
  input  logic [VW:0]   rem_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_out,
  output logic          q_bit
);

  logic [VW+1:0] shifted;
  logic [VW+1:0] dvs_ext;
  logic [VW+1:0] diff;

  // One extra bit of headroom keeps the shifted value exact before the compare.
  always_comb begin
    shifted = {rem_in, bit_in};
    dvs_ext = {2'b00, divisor};
    diff    = shifted - dvs_ext;
    q_bit   = (shifted >= dvs_ext);
    rem_out = q_bit ? diff[VW:0] : shifted[VW:0];
  end

endmodule

// File: rtl/mac_div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Define MAC_DIV_SEQ_EARLY_EXIT_EN to finish in one edge when dividend < divisor.
module mac_div_seq
  import mac_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (CNT_W > cnt_width(DW)) ? CNT_W : cnt_width(DW);

  state_t        state;
  logic [DW-1:0] qreg;
  logic [VW:0]   rem;
  logic [VW-1:0] dvs;
  logic [CW-1:0] cnt;
  logic [VW:0]   rem_next;
  logic          q_bit;

  mac_div_step #(.VW(VW)) u_step (
    .rem_in  (rem),
    .bit_in  (qreg[DW-1]),
    .divisor (dvs),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // The quotient register doubles as the dividend shift register while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      qreg        <= '0;
      rem         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            qreg        <= dividend;
            dvs         <= divisor;
            rem         <= '0;
            cnt         <= CW'(DW);
            in_ready    <= 1'b0;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              qreg        <= '1;
              rem         <= {1'b0, dividend[VW-1:0]};
              div_by_zero <= 1'b1;
            end
`ifdef MAC_DIV_SEQ_EARLY_EXIT_EN
            else if (dividend < DW'(divisor)) begin
              state     <= DONE;
              out_valid <= 1'b1;
              qreg      <= '0;
              rem       <= {1'b0, dividend[VW-1:0]};
            end
`endif
            else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          qreg <= {qreg[DW-2:0], q_bit};
          rem  <= rem_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign quotient  = qreg;
  assign remainder = rem[VW-1:0];

endmodule
